// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (A: ALU, B: load) and the
// register-file write port driven by the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] inC;
  logic [DATA_W-1:0] out;
  logic              b_boost;
  logic [CNT_W-1:0]  wr_count;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, RegWrite, inC, out, b_boost, wr_count
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, RegWrite, inC, out, b_boost, wr_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register file write port: fixed
// priority to A, with B boosted after MAX_WAIT denied cycles. Optional macro
// REGFILE_ZERO_GUARD_EN drops writes to register 0 after the handshake.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              boost_q;
  logic              reg_write_q;
  logic [ADDR_W-1:0] inc_q;
  logic [DATA_W-1:0] out_q;
  logic [CNT_W-1:0]  wr_count_q;

  logic              a_rdy;
  logic              b_rdy;
  logic              a_xfer;
  logic              b_xfer;
  logic              commit;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grants are mutually exclusive whenever both requesters are valid.
  always_comb begin
    a_rdy  = ~reset & ~(boost_q & bus.b_valid);
    b_rdy  = ~reset & (~bus.a_valid | boost_q);
    a_xfer = bus.a_valid & a_rdy;
    b_xfer = bus.b_valid & b_rdy;
    sel_addr = b_xfer ? bus.b_addr : bus.a_addr;
    sel_data = b_xfer ? bus.b_data : bus.a_data;
`ifdef REGFILE_ZERO_GUARD_EN
    commit = (a_xfer | b_xfer) & (sel_addr != '0);
`else
    commit = a_xfer | b_xfer;
`endif
  end

  always_comb begin
    wait_next = '0;
    if (bus.b_valid & ~b_rdy) begin
      if (wait_cnt == WAIT_W'(MAX_WAIT))
        wait_next = wait_cnt;
      else
        wait_next = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      inc_q       <= '0;
      out_q       <= '0;
      wait_cnt    <= '0;
      boost_q     <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      reg_write_q <= commit;
      if (commit) begin
        inc_q      <= sel_addr;
        out_q      <= sel_data;
        wr_count_q <= wr_count_q + 1'b1;
      end
      wait_cnt <= wait_next;
      boost_q  <= (wait_next == WAIT_W'(MAX_WAIT));
    end
  end

  assign bus.a_ready  = a_rdy;
  assign bus.b_ready  = b_rdy;
  assign bus.RegWrite = reg_write_q;
  assign bus.inC      = inc_q;
  assign bus.out      = out_q;
  assign bus.b_boost  = boost_q;
  assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed steps push expected writes,
// a negedge monitor pops them whenever RegWrite is presented.
module tb_regfile_wb_arbiter;
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic reset;
  int   checks;
  int   passes;
  wr_t  expQ[$];
  wr_t  monExp;
  logic [31:0] regFile [32];

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus ();

  regfile_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .MAX_WAIT(4), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    else
      passes++;
  endtask

  // Drives one cycle of requests at the negedge; registered outputs are stable here.
  task automatic applyStimulus(input logic r, input logic aV, input logic [4:0] aA,
                               input logic [31:0] aD, input logic bV,
                               input logic [4:0] bA, input logic [31:0] bD);
    @(negedge clk);
    reset       = r;
    bus.a_valid = aV;
    bus.a_addr  = aA;
    bus.a_data  = aD;
    bus.b_valid = bV;
    bus.b_addr  = bA;
    bus.b_data  = bD;
    #1;
  endtask

  task automatic pushExp(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (bus.RegWrite === 1'b1) begin
      regFile[bus.inC] <= bus.out;
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_write: got inC=%0d out=%h expected no write at %0t",
                 bus.inC, bus.out, $time);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("write_addr", 32'(bus.inC), 32'(monExp.addr));
        checkOutput("write_data", bus.out, monExp.data);
      end
    end
  end

  initial begin
    checks = 0;
    passes = 0;
    for (int i = 0; i < 32; i++) regFile[i] = 32'h0;

    // Reset held two cycles with both requesters asserting.
    reset = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'hDEAD_BEEF;
    bus.b_valid = 1'b1; bus.b_addr = 5'd8; bus.b_data = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_a_ready", 32'(bus.a_ready), 32'd0);
    checkOutput("rst_b_ready", 32'(bus.b_ready), 32'd0);
    checkOutput("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
    checkOutput("rst_inC", 32'(bus.inC), 32'd0);
    checkOutput("rst_out", bus.out, 32'd0);
    checkOutput("rst_wr_count", 32'(bus.wr_count), 32'd0);
    checkOutput("rst_b_boost", 32'(bus.b_boost), 32'd0);
    idle();

    // A only: one write, visible for exactly one cycle.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'h0);
    checkOutput("aonly_a_ready", 32'(bus.a_ready), 32'd1);
    pushExp(5'd5, 32'h0000_00AA);
    idle();
    checkOutput("aonly_RegWrite", 32'(bus.RegWrite), 32'd1);
    checkOutput("aonly_inC", 32'(bus.inC), 32'd5);
    checkOutput("aonly_out", bus.out, 32'h0000_00AA);
    checkOutput("aonly_wr_count", 32'(bus.wr_count), 32'd1);
    idle();
    checkOutput("aonly_RegWrite_drop", 32'(bus.RegWrite), 32'd0);
    checkOutput("aonly_reg5", regFile[5], 32'h0000_00AA);

    // Contention: B denied four times, boosted, wins once, then A resumes.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), 32'hA0 + 32'(i), 1'b1, 5'd9, 32'h55);
      checkOutput("cont_a_ready", 32'(bus.a_ready), 32'd1);
      checkOutput("cont_b_ready", 32'(bus.b_ready), 32'd0);
      checkOutput("cont_b_boost", 32'(bus.b_boost), 32'd0);
      pushExp(5'(i), 32'hA0 + 32'(i));
    end
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hA5, 1'b1, 5'd9, 32'h55);
    checkOutput("boost_b_boost", 32'(bus.b_boost), 32'd1);
    checkOutput("boost_a_ready", 32'(bus.a_ready), 32'd0);
    checkOutput("boost_b_ready", 32'(bus.b_ready), 32'd1);
    pushExp(5'd9, 32'h55);
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'h0);
    checkOutput("post_boost_clear", 32'(bus.b_boost), 32'd0);
    checkOutput("post_boost_a_ready", 32'(bus.a_ready), 32'd1);
    pushExp(5'd5, 32'hA5);
    applyStimulus(1'b0, 1'b1, 5'd6, 32'hA6, 1'b0, 5'd0, 32'h0);
    pushExp(5'd6, 32'hA6);
    idle();
    idle();
    checkOutput("cont_wr_count", 32'(bus.wr_count), 32'd8);

    // Same-address race after a fresh reset.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    idle();
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    checkOutput("race_a_ready", 32'(bus.a_ready), 32'd1);
    checkOutput("race_b_ready", 32'(bus.b_ready), 32'd0);
    pushExp(5'd3, 32'h11);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h22);
    checkOutput("race_b_ready2", 32'(bus.b_ready), 32'd1);
    pushExp(5'd3, 32'h22);
    idle();
    idle();
    checkOutput("race_reg3", regFile[3], 32'h22);
    checkOutput("race_wr_count", 32'(bus.wr_count), 32'd2);

    // Register 0 write: dropped only when the zero guard is built in.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    checkOutput("zero_a_ready", 32'(bus.a_ready), 32'd1);
`ifndef REGFILE_ZERO_GUARD_EN
    pushExp(5'd0, 32'hFFFF_FFFF);
`endif
    idle();
`ifdef REGFILE_ZERO_GUARD_EN
    checkOutput("zero_RegWrite", 32'(bus.RegWrite), 32'd0);
    checkOutput("zero_wr_count", 32'(bus.wr_count), 32'd2);
`else
    checkOutput("zero_RegWrite", 32'(bus.RegWrite), 32'd1);
    checkOutput("zero_inC", 32'(bus.inC), 32'd0);
    checkOutput("zero_wr_count", 32'(bus.wr_count), 32'd3);
`endif
    idle();

    // Reset mid-stream with B starved for three cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(10 + i), 32'hC0 + 32'(i), 1'b1, 5'd20, 32'h77);
      pushExp(5'(10 + i), 32'hC0 + 32'(i));
    end
    applyStimulus(1'b1, 1'b1, 5'd13, 32'hC3, 1'b1, 5'd20, 32'h77);
    checkOutput("midrst_a_ready", 32'(bus.a_ready), 32'd0);
    checkOutput("midrst_b_ready", 32'(bus.b_ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd13, 32'hC3, 1'b1, 5'd20, 32'h77);
    checkOutput("midrst_RegWrite", 32'(bus.RegWrite), 32'd0);
    checkOutput("midrst_b_boost", 32'(bus.b_boost), 32'd0);
    checkOutput("midrst_wr_count", 32'(bus.wr_count), 32'd0);
    checkOutput("midrst_a_ready2", 32'(bus.a_ready), 32'd1);
    pushExp(5'd13, 32'hC3);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(13 + i), 32'hC3 + 32'(i), 1'b1, 5'd20, 32'h77);
      checkOutput("midrst_no_boost", 32'(bus.b_boost), 32'd0);
      pushExp(5'(13 + i), 32'hC3 + 32'(i));
    end
    applyStimulus(1'b0, 1'b1, 5'd17, 32'hC7, 1'b1, 5'd20, 32'h77);
    checkOutput("midrst_boost", 32'(bus.b_boost), 32'd1);
    pushExp(5'd20, 32'h77);
    applyStimulus(1'b0, 1'b1, 5'd17, 32'hC7, 1'b0, 5'd0, 32'h0);
    pushExp(5'd17, 32'hC7);
    idle();
    idle();
    checkOutput("midrst_final_count", 32'(bus.wr_count), 32'd6);
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (RegWrite / inC / out, committed by the register file on negedge clk) between two writeback requesters: A (ALU results) and B (load data). Fixed priority to A, with a starvation counter that boosts B after MAX_WAIT denied cycles. The outputs are registered, so the register file sees a stable write for a full cycle. One write is committed per cycle at most.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register index width
MAX_WAIT, 4, consecutive denied cycles of B before B gets priority (>=1)
CNT_W, 16, width of wr_count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
a_valid  input  1  requester A has a write pending
a_ready  output  1  A accepted this cycle when a_valid & a_ready
a_addr  input  ADDR_W  A destination register
a_data  input  DATA_W  A write data
b_valid  input  1  requester B has a write pending
b_ready  output  1  B accepted this cycle when b_valid & b_ready
b_addr  input  ADDR_W  B destination register
b_data  input  DATA_W  B write data
RegWrite  output  1  write enable to register file (registered)
inC  output  ADDR_W  write address to register file (registered)
out  output  DATA_W  write data to register file (registered)
b_boost  output  1  B currently holds priority (wait counter saturated)
wr_count  output  CNT_W  count of committed writes

Behaviour:
- One clock (clk) only. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: RegWrite=0, inC=0, out=0, wait_cnt=0, b_boost=0, wr_count=0.
- While reset=1: a_ready=0 and b_ready=0, and no transfer occurs.
- Ready logic (combinational, outside reset):
  - a_ready = ~(b_boost & b_valid)
  - b_ready = ~a_valid | b_boost
- The grant does not depend on the requester's own valid. Exactly one transfer occurs when both requesters are valid.
- Requester protocol: once raised, valid/addr/data are held stable until the transfer. The arbiter does not check this.
- Commit: on a rising edge with a transfer from X, the next state is RegWrite=1, inC=X_addr, out=X_data.
- With no transfer: RegWrite<=0, and inC/out hold their previous values.
- Latency: request accepted at edge k. RegWrite is high from edge k to edge k+1, and the register file writes at the negedge between them. Throughput is 1 write per cycle.
- Starvation counter (wait_cnt, range 0..MAX_WAIT):
  - b_valid & ~b_ready: increments, saturating at MAX_WAIT.
  - B transfer or ~b_valid: clears to 0.
  - b_boost = (wait_cnt == MAX_WAIT), registered.
- Priority sequence: with A valid every cycle and B valid, B is denied for MAX_WAIT cycles. B is then accepted on the next cycle, while A stalls for that one cycle.
- Both requesters targeting the same address in the same cycle: the winner commits first and the loser on a later cycle. The last committed value wins in the register file.
- wr_count increments by 1 on each edge where RegWrite is set to 1, and wraps from 2^CNT_W-1 to 0.
- Reset mid-stream: any pending (not yet accepted) requests are ignored. Any registered write is cancelled (RegWrite=0 after the reset edge). Requesters must re-present after reset is released.

Optional Feature:
REGFILE_ZERO_GUARD_EN
- Defined: a transfer with addr==0 is accepted normally (ready/handshake unchanged), but RegWrite stays 0, inC/out hold, and wr_count does not increment. This keeps register 0 hard-wired to zero.
- Undefined: addr 0 is committed like any other register.

Test Plan:
- Reset, then idle: reset=1 for 2 cycles with both valid -> a_ready=b_ready=0, RegWrite=0, inC=0, out=0, wr_count=0.
- A only: a_valid=1, a_addr=5, a_data=0x0000_00AA for 1 cycle -> RegWrite=1 for exactly the next cycle, inC=5, out=0xAA, the register file holds 0xAA at index 5 after the negedge, wr_count=1.
- Contention with starvation (MAX_WAIT=4): A valid every cycle with addr 1..N, B valid with addr 9, data 0x55 -> A wins 4 cycles, b_boost=1, then B commits (inC=9, out=0x55) with a_ready=0 that cycle, wait_cnt=0, then A resumes.
- Same-address race: A (addr 3, 0x11) and B (addr 3, 0x22) simultaneous, no boost -> commit 0x11 then 0x22, final reg3=0x22, wr_count=2.
- Reset mid-stream: B starved with wait_cnt=3, reset asserted for 1 cycle -> wait_cnt=0, b_boost=0, RegWrite=0 after the reset edge, the pending write is lost.
- REGFILE_ZERO_GUARD_EN defined: A writes addr 0, data 0xFFFF_FFFF -> a_ready=1, RegWrite stays 0, wr_count unchanged. Undefined: RegWrite=1, inC=0.
